// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared accumulator width derivation and FSM state type
package booth_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic int acc_width(input int n, input int g);
      return 2 * n + g;
   endfunction

endpackage

// File: rtl/booth_acc_add.sv
// rtl/booth_acc_add.sv - signed accumulate adder; ACC_SATURATE_EN selects clamp+overflow flag, else wrap
module booth_acc_add #(
   parameter int W = 72
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o,
   output logic                ovf_o
);

`ifdef ACC_SATURATE_EN
   logic signed [W-1:0] raw;
   logic                over;

   // Overflow only when both operands share a sign the result does not.
   always_comb begin
      raw   = a_i + b_i;
      over  = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
      sum_o = raw;
      ovf_o = over;
      if (over) begin
         sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   always_comb begin
      sum_o = a_i + b_i;
      ovf_o = 1'b0;
   end
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - accumulates signed Booth products into blocks; ACC_SATURATE_EN enables clamping and out_ovf
module booth_product_accumulator
   import booth_pkg::*;
#(
   parameter  int N     = 32,
   parameter  int G     = 8,
   parameter  int CW    = 16,
   localparam int ACC_W = acc_width(N, G)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*N-1:0]          in_product,
   input  logic                    in_last,
   input  logic                    clear,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_acc,
   output logic [CW-1:0]           out_count,
   output logic                    out_ovf
);

   state_t                  state_q, state_d;
   logic                    live_q, live_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
   logic [CW-1:0]           count_q, count_d, out_count_q, out_count_d;
   logic                    ovf_q, ovf_d;
   logic signed [ACC_W-1:0] base_acc, prod_ext, sum;
   logic [CW-1:0]           base_cnt, cnt_inc;
   logic                    base_ovf, add_ovf, new_ovf;
   logic                    accept;

   assign accept   = in_valid && in_ready;
   assign prod_ext = ACC_W'(signed'(in_product));

   // A clear restarts the block, so the accepted beat (if any) adds onto zero.
   always_comb begin
      base_acc = clear ? '0 : acc_q;
      base_cnt = clear ? '0 : count_q;
      base_ovf = clear ? 1'b0 : ovf_q;
      cnt_inc  = (base_cnt == {CW{1'b1}}) ? base_cnt : base_cnt + CW'(1);
      new_ovf  = base_ovf | add_ovf;
   end

   booth_acc_add #(.W(ACC_W)) u_add (
      .a_i   (base_acc),
      .b_i   (prod_ext),
      .sum_o (sum),
      .ovf_o (add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (accept && in_last) state_d = HOLD;
         HOLD:    if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = live_q && (state_q == ACCUM);
      out_valid = (state_q == HOLD);
   end

   always_comb begin
      live_d      = 1'b1;
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      out_acc_d   = out_acc_q;
      out_count_d = out_count_q;
      if (state_q == ACCUM) begin
         if (accept) begin
            acc_d   = sum;
            count_d = cnt_inc;
            ovf_d   = new_ovf;
            if (in_last) begin
               out_acc_d   = sum;
               out_count_d = cnt_inc;
            end
         end else if (clear) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
         end
      end else if (out_ready) begin
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q      <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         out_acc_q   <= '0;
         out_count_q <= '0;
      end else begin
         live_q      <= live_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         out_acc_q   <= out_acc_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_acc   = out_acc_q;
   assign out_count = out_count_q;

`ifdef ACC_SATURATE_EN
   logic out_ovf_q, out_ovf_d;

   always_comb begin
      out_ovf_d = out_ovf_q;
      if ((state_q == ACCUM) && accept && in_last) out_ovf_d = new_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ovf_q <= 1'b0;
      end else begin
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out_ovf = out_ovf_q;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - directed self-checking bench for booth_product_accumulator
module tb_booth_product_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_last, clear, out_ready;
   logic [63:0] in_product;
   logic        in_ready, out_valid, out_ovf;
   logic [71:0] out_acc;
   logic [15:0] out_count;

   logic        g_in_valid, g_in_last;
   logic [63:0] g_in_product;
   logic        g_in_ready, g_out_valid, g_out_ovf;
   logic [63:0] g_out_acc;
   logic [15:0] g_out_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   booth_product_accumulator #(.N(32), .G(8), .CW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .in_last    (in_last),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_acc    (out_acc),
      .out_count  (out_count),
      .out_ovf    (out_ovf)
   );

   booth_product_accumulator #(.N(32), .G(0), .CW(16)) dut_g0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (g_in_valid),
      .in_ready   (g_in_ready),
      .in_product (g_in_product),
      .in_last    (g_in_last),
      .clear      (1'b0),
      .out_valid  (g_out_valid),
      .out_ready  (1'b0),
      .out_acc    (g_out_acc),
      .out_count  (g_out_count),
      .out_ovf    (g_out_ovf)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; presents one beat for exactly one edge.
   task automatic beat(input logic [63:0] p, input logic last, input logic clr);
      in_valid   = 1'b1;
      in_product = p;
      in_last    = last;
      clear      = clr;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 1'b0);
      chk({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 0; in_last = 0; clear = 0; out_ready = 0; in_product = '0;
      g_in_valid = 0; g_in_last = 0; g_in_product = '0;
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_acc", out_acc, 72'd0);
      chk("rst_out_count", out_count, 16'd0);
      chk("rst_out_ovf", out_ovf, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_edge_in_ready", in_ready, 1'b1);

      // 6, -15, 100 -> 91
      beat(64'd6, 1'b0, 1'b0);
      beat(-64'sd15, 1'b0, 1'b0);
      chk("t1_valid_before_last", out_valid, 1'b0);
      beat(64'd100, 1'b1, 1'b0);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_acc", out_acc, 72'd91);
      chk("t1_count", out_count, 16'd3);
      chk("t1_ovf", out_ovf, 1'b0);
      chk("t1_in_ready_hold", in_ready, 1'b0);
      consume("t1");

      // single -2^62 term, sign-extended to 72 bits
      beat(64'hC000_0000_0000_0000, 1'b1, 1'b0);
      chk("t2_acc", out_acc, 72'hFF_C000_0000_0000_0000);
      chk("t2_count", out_count, 16'd1);
      consume("t2");

      // HOLD with out_ready low: outputs stable, offered beats refused, clear ignored
      beat(64'd5, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_product = 64'd1000; in_last = 1'b1; clear = (i == 2);
         @(posedge clk); #1;
         chk("t4_valid", out_valid, 1'b1);
         chk("t4_in_ready", in_ready, 1'b0);
         chk("t4_acc", out_acc, 72'd5);
         chk("t4_count", out_count, 16'd1);
      end
      in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
      consume("t4");
      beat(64'd3, 1'b1, 1'b0);
      chk("t4_next_acc", out_acc, 72'd3);
      chk("t4_next_count", out_count, 16'd1);
      consume("t4n");

      // 10, 20, then clear with beat 7 (last)
      beat(64'd10, 1'b0, 1'b0);
      beat(64'd20, 1'b0, 1'b0);
      beat(64'd7, 1'b1, 1'b1);
      chk("t5_acc", out_acc, 72'd7);
      chk("t5_count", out_count, 16'd1);
      consume("t5");

      // clear without a beat, then a fresh single term
      beat(64'd50, 1'b0, 1'b0);
      clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
      beat(64'd2, 1'b1, 1'b0);
      chk("t5b_acc", out_acc, 72'd2);
      chk("t5b_count", out_count, 16'd1);
      consume("t5b");

      // reset mid-block
      beat(64'd4, 1'b0, 1'b0);
      beat(64'd9, 1'b0, 1'b0);
      #2 rst_n = 1'b0; #1;
      chk("t6_in_ready", in_ready, 1'b0);
      chk("t6_out_valid", out_valid, 1'b0);
      chk("t6_out_acc", out_acc, 72'd0);
      chk("t6_out_count", out_count, 16'd0);
      chk("t6_out_ovf", out_ovf, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      beat(64'd11, 1'b1, 1'b0);
      chk("t6_next_acc", out_acc, 72'd11);
      chk("t6_next_count", out_count, 16'd1);
      consume("t6");

      // G=0: (2^63-1) twice
      g_in_valid = 1'b1; g_in_product = 64'h7FFF_FFFF_FFFF_FFFF; g_in_last = 1'b0;
      @(posedge clk); #1;
      g_in_last = 1'b1;
      @(posedge clk); #1;
      g_in_valid = 1'b0; g_in_last = 1'b0;
      chk("t3_valid", g_out_valid, 1'b1);
      chk("t3_count", g_out_count, 16'd2);
`ifdef ACC_SATURATE_EN
      chk("t3_acc", g_out_acc, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("t3_ovf", g_out_ovf, 1'b1);
`else
      chk("t3_acc", g_out_acc, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("t3_ovf", g_out_ovf, 1'b0);
`endif
      chk("t3_in_ready", g_in_ready, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
